xm_fetch_unit: RTL and testbench

- Instruction fetch stage that sits directly upstream of the instruction decoder.
- Owns the fetch PC and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned words with their addresses in a small prefetch queue and presents them to the decoder/control path with a valid/ready handshake.
- Accepts branch/jump/trap redirects from the control unit and flushes wrong-path words.

---
 rtl/xm_pkg.sv | 26 ++
 rtl/xm_fetch_queue.sv | 79 +++++++
 rtl/xm_fetch_unit.sv | 190 +++++++++++++++++++
 tb/tb_xm_fetch_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xm_pkg.sv
// Shared types and defaults for the xm instruction fetch unit.
// The fetch_entry_t field widths come from XM_WORD/XM_ADDR.
package xm_pkg;

    localparam int XM_WORD = 16;
    localparam int XM_ADDR = 16;
    localparam logic [XM_ADDR-1:0] XM_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2,
        HALT = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [XM_ADDR-1:0] pc;
        logic [XM_WORD-1:0] inst;
    } fetch_entry_t;

    // Sequential fetch address; wraps naturally modulo 2^XM_ADDR.
    function automatic logic [XM_ADDR-1:0] next_fetch_pc(input logic [XM_ADDR-1:0] pc);
        return pc + XM_ADDR'(2);
    endfunction

endpackage

// File: rtl/xm_fetch_queue.sv
// Small synchronous FIFO of fetched {pc, inst} entries.
// Flush wins over push; a push into a full queue is only taken alongside a pop.
module xm_fetch_queue
    import xm_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         arst_ni,
    input  logic                         push_i,
    input  fetch_entry_t                 push_data_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output fetch_entry_t                 head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         empty_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_pop   = pop_i & (count_q != '0);
        do_push  = push_i & ((count_q != FULL_CNT) | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing reads it until count_q says it holds data.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/xm_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, talks req/ack to imem, buffers words for the decoder.
// Define XM_FETCH_ALIGN_CHECK_EN to fault and halt on odd redirect targets. RESET_PC must be even.
module xm_fetch_unit
    import xm_pkg::*;
#(
    parameter int              WORD     = XM_WORD,
    parameter int              ADDR     = XM_ADDR,
    parameter logic [ADDR-1:0] RESET_PC = XM_RESET_PC,
    parameter int              DEPTH    = 2
) (
    input  logic            clk_i,
    input  logic            arst_ni,
    output logic            imem_req_o,
    output logic [ADDR-1:0] imem_adr_o,
    input  logic            imem_ack_i,
    input  logic [WORD-1:0] imem_data_i,
    output logic [WORD-1:0] inst_o,
    output logic [ADDR-1:0] instPc_o,
    output logic            instValid_o,
    input  logic            instReady_i,
    input  logic            redirect_i,
    input  logic [ADDR-1:0] redirectPc_i,
    output logic            fault_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(DEPTH);

    fetch_state_t    state_q, state_d;
    logic [ADDR-1:0] adr_q, adr_d;
    logic [ADDR-1:0] tgt_q, tgt_d;
    fetch_entry_t    hold_q, hold_d;

    logic            push;
    logic            flush;
    logic            pop;
    fetch_entry_t    push_entry;
    fetch_entry_t    q_head;
    logic [CNT_W-1:0] q_count;
    logic            q_empty;
    fetch_entry_t    disp;
    logic [ADDR-1:0] redir_pc;
    logic [CNT_W:0]  cnt_ext;
    logic [CNT_W:0]  occ_pop;
    logic [CNT_W:0]  occ_push_pop;

`ifdef XM_FETCH_ALIGN_CHECK_EN
    logic            fault_q, fault_d;
    logic            halt_q, halt_d;
    logic            redir_odd;

    assign redir_odd = redirectPc_i[0];
`endif

    assign redir_pc     = redirectPc_i & ~ADDR'(1);
    assign pop          = ~q_empty & instReady_i & ~redirect_i;
    assign push_entry   = '{pc: adr_q, inst: imem_data_i};
    assign cnt_ext      = {1'b0, q_count};
    assign occ_pop      = cnt_ext - (CNT_W + 1)'(pop);
    assign occ_push_pop = cnt_ext + (CNT_W + 1)'(1) - (CNT_W + 1)'(pop);

    xm_fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk_i      (clk_i),
        .arst_ni    (arst_ni),
        .push_i     (push),
        .push_data_i(push_entry),
        .pop_i      (pop),
        .flush_i    (flush),
        .head_o     (q_head),
        .count_o    (q_count),
        .empty_o    (q_empty)
    );

    // A redirect with a request still in flight parks in DROP so the stale word is swallowed.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        tgt_d   = tgt_q;
        push    = 1'b0;
        flush   = 1'b0;
`ifdef XM_FETCH_ALIGN_CHECK_EN
        fault_d = fault_q;
        halt_d  = halt_q;
`endif
        if (redirect_i) begin
            flush = 1'b1;
`ifdef XM_FETCH_ALIGN_CHECK_EN
            fault_d = redir_odd;
`endif
            if (imem_req_o && !imem_ack_i) begin
                state_d = DROP;
                tgt_d   = redir_pc;
`ifdef XM_FETCH_ALIGN_CHECK_EN
                halt_d  = redir_odd;
`endif
            end else begin
`ifdef XM_FETCH_ALIGN_CHECK_EN
                halt_d = 1'b0;
                if (redir_odd) begin
                    state_d = HALT;
                end else begin
                    state_d = REQ;
                    adr_d   = redir_pc;
                end
`else
                state_d = REQ;
                adr_d   = redir_pc;
`endif
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (occ_pop < DEPTH_V) begin
                        state_d = REQ;
                    end
                end
                REQ: begin
                    if (imem_ack_i) begin
                        push    = 1'b1;
                        adr_d   = next_fetch_pc(adr_q);
                        state_d = (occ_push_pop < DEPTH_V) ? REQ : IDLE;
                    end
                end
                DROP: begin
                    if (imem_ack_i) begin
                        adr_d   = tgt_q;
                        state_d = REQ;
`ifdef XM_FETCH_ALIGN_CHECK_EN
                        if (halt_q) begin
                            state_d = HALT;
                        end
                        halt_d = 1'b0;
`endif
                    end
                end
`ifdef XM_FETCH_ALIGN_CHECK_EN
                HALT: begin
                    state_d = HALT;
                end
`endif
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= IDLE;
            adr_q   <= RESET_PC;
            tgt_q   <= RESET_PC;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            tgt_q   <= tgt_d;
            hold_q  <= hold_d;
        end
    end

`ifdef XM_FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            fault_q <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            fault_q <= fault_d;
            halt_q  <= halt_d;
        end
    end

    assign fault_o = fault_q;
`else
    assign fault_o = 1'b0;
`endif

    // With the queue empty the outputs keep showing whatever was presented last.
    assign disp   = q_empty ? hold_q : q_head;
    assign hold_d = disp;

    assign imem_req_o  = (state_q == REQ) || (state_q == DROP);
    assign imem_adr_o  = adr_q;
    assign instValid_o = ~q_empty;
    assign inst_o      = disp.inst;
    assign instPc_o    = disp.pc;

endmodule

// File: tb/tb_xm_fetch_unit.sv
// Scoreboard bench for xm_fetch_unit: stimulus queues expected deliveries, a monitor checks them.
// Test 6 expectations follow XM_FETCH_ALIGN_CHECK_EN.
module tb_xm_fetch_unit;

    logic        clk_i   = 1'b0;
    logic        arst_ni = 1'b0;
    logic        imem_req_o;
    logic [15:0] imem_adr_o;
    logic        imem_ack_i   = 1'b0;
    logic [15:0] imem_data_i  = 16'h0000;
    logic [15:0] inst_o;
    logic [15:0] instPc_o;
    logic        instValid_o;
    logic        instReady_i  = 1'b0;
    logic        redirect_i   = 1'b0;
    logic [15:0] redirectPc_i = 16'h0000;
    logic        fault_o;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] inst;
    } exp_t;

    exp_t expQ[$];
    int   passCount  = 0;
    int   checkCount = 0;
    int   memLat     = 0;
    int   memWait    = 0;

    always #5 clk_i = ~clk_i;

    xm_fetch_unit #(
        .WORD    (16),
        .ADDR    (16),
        .RESET_PC(16'h0000),
        .DEPTH   (2)
    ) dut (
        .clk_i       (clk_i),
        .arst_ni     (arst_ni),
        .imem_req_o  (imem_req_o),
        .imem_adr_o  (imem_adr_o),
        .imem_ack_i  (imem_ack_i),
        .imem_data_i (imem_data_i),
        .inst_o      (inst_o),
        .instPc_o    (instPc_o),
        .instValid_o (instValid_o),
        .instReady_i (instReady_i),
        .redirect_i  (redirect_i),
        .redirectPc_i(redirectPc_i),
        .fault_o     (fault_o)
    );

    function automatic logic [15:0] memWord(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC35A;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic ready, input logic redir, input logic [15:0] redirPc);
        instReady_i  = ready;
        redirect_i   = redir;
        redirectPc_i = redirPc;
    endtask

    task automatic expectWord(input logic [15:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = memWord(pc);
        expQ.push_back(e);
    endtask

    task automatic applyReset(input int lat);
        arst_ni = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0000);
        memLat = lat;
        #1;
        checkOutput("reset req", {15'd0, imem_req_o}, 16'h0000);
        checkOutput("reset adr", imem_adr_o, 16'h0000);
        checkOutput("reset valid", {15'd0, instValid_o}, 16'h0000);
        checkOutput("reset inst", inst_o, 16'h0000);
        checkOutput("reset pc", instPc_o, 16'h0000);
        checkOutput("reset fault", {15'd0, fault_o}, 16'h0000);
        expQ.delete();
        repeat (2) nextCycle();
        arst_ni = 1'b1;
    endtask

    task automatic drainScoreboard(input string name, input int limit);
        int n = 0;
        while (expQ.size() != 0 && n < limit) begin
            @(posedge clk_i);
            n++;
        end
        #1;
        instReady_i = 1'b0;
        checkOutput({name, " drained"}, 16'(expQ.size()), 16'h0000);
        expQ.delete();
    endtask

    // Memory model: ack after memLat waiting cycles, one word per request.
    always @(posedge clk_i) begin
        #1;
        if (imem_req_o) begin
            if (memWait >= memLat) begin
                imem_ack_i  = 1'b1;
                imem_data_i = memWord(imem_adr_o);
                memWait     = 0;
            end else begin
                imem_ack_i  = 1'b0;
                imem_data_i = 16'hDEAD;
                memWait++;
            end
        end else begin
            imem_ack_i = 1'b0;
            memWait    = 0;
        end
    end

    // Monitor: every accepted word (not killed by a redirect) must match the scoreboard head.
    always @(negedge clk_i) begin
        if (arst_ni && instValid_o && instReady_i && !redirect_i) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected delivery pc", instPc_o, 16'hFFFF ^ instPc_o);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("deliver pc", instPc_o, e.pc);
                checkOutput("deliver inst", inst_o, e.inst);
            end
        end
    end

    initial begin
        logic found;

        // 1: zero-wait streaming
        applyReset(0);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        for (int k = 0; k < 6; k++) expectWord(16'(2 * k));
        for (int k = 0; k < 6; k++) begin
            nextCycle();
            checkOutput($sformatf("t1 req c%0d", k), {15'd0, imem_req_o}, 16'h0001);
            checkOutput($sformatf("t1 adr c%0d", k), imem_adr_o, 16'(2 * k));
            if (k == 0) checkOutput("t1 valid before first push", {15'd0, instValid_o}, 16'h0000);
        end
        drainScoreboard("t1", 50);

        // 2: consumer stalled fills the queue, then release
        applyReset(0);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        expectWord(16'h0000); expectWord(16'h0002); expectWord(16'h0004); expectWord(16'h0006);
        repeat (3) nextCycle();
        checkOutput("t2 req full", {15'd0, imem_req_o}, 16'h0000);
        checkOutput("t2 adr full", imem_adr_o, 16'h0004);
        checkOutput("t2 head pc", instPc_o, 16'h0000);
        nextCycle();
        checkOutput("t2 req still idle", {15'd0, imem_req_o}, 16'h0000);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        nextCycle();
        checkOutput("t2 req resumed", {15'd0, imem_req_o}, 16'h0001);
        checkOutput("t2 adr resumed", imem_adr_o, 16'h0004);
        drainScoreboard("t2", 50);

        // 3: slow memory, redirect while request at 6 is in flight
        applyReset(3);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        expectWord(16'h0000); expectWord(16'h0002); expectWord(16'h0004);
        expectWord(16'h0100); expectWord(16'h0102);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            nextCycle();
            if (imem_req_o && imem_adr_o == 16'h0006) found = 1'b1;
        end
        checkOutput("t3 reached adr 6", {15'd0, found}, 16'h0001);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 16'h0100);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("t3 drop req", {15'd0, imem_req_o}, 16'h0001);
        checkOutput("t3 drop adr held", imem_adr_o, 16'h0006);
        nextCycle();
        checkOutput("t3 drop adr still held", imem_adr_o, 16'h0006);
        nextCycle();
        checkOutput("t3 target adr", imem_adr_o, 16'h0100);
        drainScoreboard("t3", 100);

        // 4: redirect coincident with ack and pop
        applyReset(0);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        expectWord(16'h0040); expectWord(16'h0042); expectWord(16'h0044);
        nextCycle();
        nextCycle();
        checkOutput("t4 valid before redirect", {15'd0, instValid_o}, 16'h0001);
        checkOutput("t4 head pc before redirect", instPc_o, 16'h0000);
        applyStimulus(1'b1, 1'b1, 16'h0040);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("t4 flushed", {15'd0, instValid_o}, 16'h0000);
        checkOutput("t4 req", {15'd0, imem_req_o}, 16'h0001);
        checkOutput("t4 adr", imem_adr_o, 16'h0040);
        drainScoreboard("t4", 50);

        // 5: address wrap at the top of the space
        applyReset(0);
        applyStimulus(1'b1, 1'b1, 16'hFFFC);
        expectWord(16'hFFFC); expectWord(16'hFFFE); expectWord(16'h0000);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 16'h0000);
        checkOutput("t5 adr FFFC", imem_adr_o, 16'hFFFC);
        nextCycle();
        checkOutput("t5 adr FFFE", imem_adr_o, 16'hFFFE);
        nextCycle();
        checkOutput("t5 adr wrap", imem_adr_o, 16'h0000);
        drainScoreboard("t5", 50);

        // 6: odd redirect target, then even
        applyReset(0);
        applyStimulus(1'b0, 1'b1, 16'h0201);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 16'h0000);
`ifdef XM_FETCH_ALIGN_CHECK_EN
        checkOutput("t6 fault set", {15'd0, fault_o}, 16'h0001);
        checkOutput("t6 halted req", {15'd0, imem_req_o}, 16'h0000);
`else
        checkOutput("t6 fault tied", {15'd0, fault_o}, 16'h0000);
        checkOutput("t6 forced even req", {15'd0, imem_req_o}, 16'h0001);
        checkOutput("t6 forced even adr", imem_adr_o, 16'h0200);
`endif
        nextCycle();
        nextCycle();
`ifdef XM_FETCH_ALIGN_CHECK_EN
        checkOutput("t6 still halted", {15'd0, imem_req_o}, 16'h0000);
        checkOutput("t6 fault sticky", {15'd0, fault_o}, 16'h0001);
`endif
        applyStimulus(1'b0, 1'b1, 16'h0200);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 16'h0000);
        expectWord(16'h0200); expectWord(16'h0202);
        checkOutput("t6 resume req", {15'd0, imem_req_o}, 16'h0001);
        checkOutput("t6 resume adr", imem_adr_o, 16'h0200);
        checkOutput("t6 fault cleared", {15'd0, fault_o}, 16'h0000);
        drainScoreboard("t6", 50);

        repeat (2) nextCycle();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
